rocc_mem_arbiter: RTL and testbench

- Shares the single accelerator memory port between two RoCC-style accelerators (e.g. digitrec plus a second kernel).
- Uses 124-bit mem_req and 253-bit mem_resp packed buses in the existing field layout.
- Registered round-robin request path; tag-based response routing; per-requester outstanding-request credit limit.
- Sits between the accelerator wrappers and the core's memory port.

---
 rtl/rocc_mem_pkg.sv | 66 ++++++
 rtl/rocc_mem_credit.sv | 41 ++++
 rtl/rocc_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rocc_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_mem_pkg.sv
// Shared widths, field offsets and helpers for the RoCC memory arbiter.
package rocc_mem_pkg;

  localparam int unsigned MEM_REQ_W  = 124;
  localparam int unsigned MEM_RESP_W = 253;
  localparam int unsigned TAG_W      = 10;
  localparam int unsigned TAG_ID_BIT = 9;

  // Request layout {addr40, tag10, cmd5, typ3, kill, phys, data64}
  localparam int unsigned REQ_DATA_LSB = 0;
  localparam int unsigned REQ_PHYS_BIT = 64;
  localparam int unsigned REQ_KILL_BIT = 65;
  localparam int unsigned REQ_TYP_LSB  = 66;
  localparam int unsigned REQ_CMD_LSB  = 69;
  localparam int unsigned REQ_TAG_LSB  = 74;
  localparam int unsigned REQ_TAG_MSB  = 83;
  localparam int unsigned REQ_ADDR_LSB = 84;
  localparam int unsigned REQ_ADDR_MSB = 123;

  // Response layout {addr40, tag10, cmd5, typ3, data64, nack, replay, has_data,
  //                  bypass64, store64}
  localparam int unsigned RESP_STORE_LSB  = 0;
  localparam int unsigned RESP_BYPASS_LSB = 64;
  localparam int unsigned RESP_HAS_DATA   = 128;
  localparam int unsigned RESP_REPLAY     = 129;
  localparam int unsigned RESP_NACK       = 130;
  localparam int unsigned RESP_DATA_LSB   = 131;
  localparam int unsigned RESP_TYP_LSB    = 195;
  localparam int unsigned RESP_CMD_LSB    = 198;
  localparam int unsigned RESP_TAG_LSB    = 203;
  localparam int unsigned RESP_TAG_MSB    = 212;
  localparam int unsigned RESP_ADDR_LSB   = 213;
  localparam int unsigned RESP_ADDR_MSB   = 252;

  // Absolute bit positions of the requester-id tag bit
  localparam int unsigned REQ_ID_BIT  = REQ_TAG_LSB + TAG_ID_BIT;
  localparam int unsigned RESP_ID_BIT = RESP_TAG_LSB + TAG_ID_BIT;

  typedef logic [MEM_REQ_W-1:0]  mem_req_t;
  typedef logic [MEM_RESP_W-1:0] mem_resp_t;

  // Overwrite the tag id bit of a request with the granted requester id
  function automatic mem_req_t set_req_id(input mem_req_t r, input logic id);
    mem_req_t o;
    o = r;
    o[REQ_ID_BIT] = id;
    return o;
  endfunction

  // Strip the requester id bit so the requester sees its original tag
  function automatic mem_resp_t clr_resp_id(input mem_resp_t r);
    mem_resp_t o;
    o = r;
    o[RESP_ID_BIT] = 1'b0;
    return o;
  endfunction

  // 32-bit saturating increment
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/rocc_mem_credit.sv
// Per-requester outstanding-request counter: full flag gates new grants,
// uflow flags a response arriving while nothing is outstanding.
module rocc_mem_credit #(
  parameter int unsigned  MAX_OUTSTANDING = 8,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             uflow
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: inc and dec together cancel; never drop below zero
  always_comb begin
    cnt_d = cnt_q;
    uflow = dec && (cnt_q == '0);
    if (inc && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!inc && dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign full = (cnt_q == CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/rocc_mem_arbiter.sv
// Two-requester round-robin arbiter onto a single RoCC memory port.
// Requests go through a one-entry output register; responses are routed back
// combinationally by tag bit 9. Optional counters under ROCC_MEM_ARB_STATS_EN.
module rocc_mem_arbiter
  import rocc_mem_pkg::*;
#(
  parameter int unsigned  MAX_OUTSTANDING = 8,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_vld,
  output logic                  req0_rdy,
  input  logic [MEM_REQ_W-1:0]  req0,
  output logic                  resp0_vld,
  output logic [MEM_RESP_W-1:0] resp0,
  input  logic                  req1_vld,
  output logic                  req1_rdy,
  input  logic [MEM_REQ_W-1:0]  req1,
  output logic                  resp1_vld,
  output logic [MEM_RESP_W-1:0] resp1,
  output logic                  mem_req_vld,
  input  logic                  mem_req_rdy,
  output logic [MEM_REQ_W-1:0]  mem_req,
  input  logic                  mem_resp_vld,
  input  logic [MEM_RESP_W-1:0] mem_resp,
  output logic                  busy,
  output logic                  err
`ifdef ROCC_MEM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_grant0,
  output logic [31:0]           stat_grant1,
  output logic [31:0]           stat_stall
`endif
);

  logic             vld_q, vld_d;
  mem_req_t         req_q, req_d;
  logic             rr_q, rr_d;
  logic             err_q, err_d;

  logic             load_ok, elig0, elig1, gnt_vld, gnt_id;
  logic             full0, full1, uflow0, uflow1;
  logic             resp_id, dec0, dec1;
  logic [CNT_W-1:0] cnt0, cnt1;

  // Grant selection and output-register next state
  always_comb begin
    load_ok = !vld_q || mem_req_rdy;
    elig0   = req0_vld && !full0;
    elig1   = req1_vld && !full1;
    gnt_vld = load_ok && (elig0 || elig1);
    // rr_q holds the last granted id; on contention the other side wins
    if (elig0 && elig1) begin
      gnt_id = ~rr_q;
    end else begin
      gnt_id = elig1;
    end
    vld_d = vld_q;
    req_d = req_q;
    rr_d  = rr_q;
    if (gnt_vld) begin
      vld_d = 1'b1;
      req_d = set_req_id(gnt_id ? req1 : req0, gnt_id);
      rr_d  = gnt_id;
    end else if (mem_req_rdy) begin
      vld_d = 1'b0;
    end
  end

  assign req0_rdy = gnt_vld && !gnt_id;
  assign req1_rdy = gnt_vld && gnt_id;

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      req_q <= '0;
      rr_q  <= 1'b1;
    end else begin
      vld_q <= vld_d;
      req_q <= req_d;
      rr_q  <= rr_d;
    end
  end

  assign mem_req_vld = vld_q;
  assign mem_req     = req_q;

  // Response routing by the id bit the arbiter inserted
  always_comb begin
    resp_id   = mem_resp[RESP_ID_BIT];
    dec0      = mem_resp_vld && !resp_id;
    dec1      = mem_resp_vld && resp_id;
    resp0_vld = dec0;
    resp1_vld = dec1;
    resp0     = clr_resp_id(mem_resp);
    resp1     = clr_resp_id(mem_resp);
  end

  rocc_mem_credit #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit0 (
    .clk  (clk),
    .rst  (rst),
    .inc  (req0_rdy),
    .dec  (dec0),
    .cnt  (cnt0),
    .full (full0),
    .uflow(uflow0)
  );

  rocc_mem_credit #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit1 (
    .clk  (clk),
    .rst  (rst),
    .inc  (req1_rdy),
    .dec  (dec1),
    .cnt  (cnt1),
    .full (full1),
    .uflow(uflow1)
  );

  // Sticky error on any orphan response
  always_comb begin
    err_d = err_q || uflow0 || uflow1;
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err  = err_q;
  assign busy = vld_q || (cnt0 != '0) || (cnt1 != '0);

`ifdef ROCC_MEM_ARB_STATS_EN
  logic [31:0] g0_q, g1_q, st_q;

  // Saturating grant and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      g0_q <= '0;
      g1_q <= '0;
      st_q <= '0;
    end else begin
      g0_q <= sat_inc32(g0_q, req0_rdy);
      g1_q <= sat_inc32(g1_q, req1_rdy);
      st_q <= sat_inc32(st_q, vld_q && !mem_req_rdy);
    end
  end

  assign stat_grant0 = g0_q;
  assign stat_grant1 = g1_q;
  assign stat_stall  = st_q;
`endif

endmodule

// File: tb/tb_rocc_mem_arbiter.sv
// Directed bench for rocc_mem_arbiter (default MAX_OUTSTANDING = 8).
module tb_rocc_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         req0_vld, req0_rdy, resp0_vld;
  logic [123:0] req0;
  logic [252:0] resp0;
  logic         req1_vld, req1_rdy, resp1_vld;
  logic [123:0] req1;
  logic [252:0] resp1;
  logic         mem_req_vld, mem_req_rdy, mem_resp_vld;
  logic [123:0] mem_req;
  logic [252:0] mem_resp;
  logic         busy, err;
`ifdef ROCC_MEM_ARB_STATS_EN
  logic [31:0]  stat_grant0, stat_grant1, stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  rocc_mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0_vld    (req0_vld),
    .req0_rdy    (req0_rdy),
    .req0        (req0),
    .resp0_vld   (resp0_vld),
    .resp0       (resp0),
    .req1_vld    (req1_vld),
    .req1_rdy    (req1_rdy),
    .req1        (req1),
    .resp1_vld   (resp1_vld),
    .resp1       (resp1),
    .mem_req_vld (mem_req_vld),
    .mem_req_rdy (mem_req_rdy),
    .mem_req     (mem_req),
    .mem_resp_vld(mem_resp_vld),
    .mem_resp    (mem_resp),
    .busy        (busy),
    .err         (err)
`ifdef ROCC_MEM_ARB_STATS_EN
    ,
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request with the given tag; other fields depend only on seed
  function automatic logic [123:0] mk_req(input logic [9:0] tag, input logic [7:0] seed);
    logic [123:0] r;
    r          = '0;
    r[123:84]  = 40'h00_1234_5000 + {32'd0, seed};
    r[83:74]   = tag;
    r[73:69]   = 5'h01;
    r[68:66]   = 3'd3;
    r[65]      = 1'b0;
    r[64]      = 1'b1;
    r[63:0]    = 64'hA5A5_0000_1234_5600 + {56'd0, seed};
    return r;
  endfunction

  // Response with the given tag; other fields constant
  function automatic logic [252:0] mk_resp(input logic [9:0] tag);
    logic [252:0] r;
    r          = '0;
    r[252:213] = 40'h00_1234_5000;
    r[212:203] = tag;
    r[202:198] = 5'h01;
    r[197:195] = 3'd3;
    r[194:131] = 64'hCAFE_F00D_0000_0001;
    r[128]     = 1'b1;
    r[127:64]  = 64'h0BAD_0000_0000_0002;
    r[63:0]    = 64'h5707_0000_0000_0003;
    return r;
  endfunction

  task automatic chk(input string name, input logic [252:0] obs, input logic [252:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_resp(input logic [9:0] tag);
    mem_resp_vld = 1'b1;
    mem_resp     = mk_resp(tag);
    tick();
    mem_resp_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_vld = 1'b0; req0 = '0;
    req1_vld = 1'b0; req1 = '0;
    mem_req_rdy = 1'b0;
    mem_resp_vld = 1'b0; mem_resp = '0;
    tick();
    tick();
    chk("rst_mem_req_vld", mem_req_vld, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // Single request from requester 0
    req0_vld = 1'b1; req0 = mk_req(10'h005, 8'd1); mem_req_rdy = 1'b1;
    #1;
    chk("single_req0_rdy", req0_rdy, 1);
    chk("single_req1_rdy", req1_rdy, 0);
    tick();
    req0_vld = 1'b0;
    #1;
    chk("single_mem_req_vld", mem_req_vld, 1);
    chk("single_mem_req", mem_req, mk_req(10'h005, 8'd1));
    tick();
    chk("single_drained", mem_req_vld, 0);
    chk("single_busy_outstanding", busy, 1);
    mem_resp_vld = 1'b1; mem_resp = mk_resp(10'h005);
    #1;
    chk("single_resp0_vld", resp0_vld, 1);
    chk("single_resp1_vld", resp1_vld, 0);
    chk("single_resp0", resp0, mk_resp(10'h005));
    tick();
    mem_resp_vld = 1'b0;
    #1;
    chk("single_busy_idle", busy, 0);
    chk("single_err", err, 0);

    // Round robin from a fresh reset: 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_vld = 1'b1; req0 = mk_req(10'h001, 8'd2);
    req1_vld = 1'b1; req1 = mk_req(10'h00A, 8'd3);
    mem_req_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_req0_rdy", req0_rdy, (i % 2) == 0);
      chk("rr_req1_rdy", req1_rdy, (i % 2) == 1);
      tick();
      chk("rr_mem_req_vld", mem_req_vld, 1);
      chk("rr_mem_req", mem_req,
          ((i % 2) == 0) ? mk_req(10'h001, 8'd2) : mk_req(10'h20A, 8'd3));
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    tick();
    chk("rr_drained", mem_req_vld, 0);
    mem_resp_vld = 1'b1; mem_resp = mk_resp(10'h20A);
    #1;
    chk("remap_resp1_vld", resp1_vld, 1);
    chk("remap_resp0_vld", resp0_vld, 0);
    chk("remap_resp1", resp1, mk_resp(10'h00A));
    tick();
    send_resp(10'h20A);
    send_resp(10'h001);
    send_resp(10'h001);
    chk("rr_busy_idle", busy, 0);
    chk("rr_err", err, 0);

    // Backpressure: held entry stays stable, pending request waits
    mem_req_rdy = 1'b0;
    req0_vld = 1'b1; req0 = mk_req(10'h233, 8'd4);
    #1;
    chk("stall_first_rdy", req0_rdy, 1);
    tick();
    req0 = mk_req(10'h034, 8'd5);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_vld", mem_req_vld, 1);
      chk("stall_stable", mem_req, mk_req(10'h033, 8'd4));
      chk("stall_req0_rdy", req0_rdy, 0);
      tick();
    end
    mem_req_rdy = 1'b1;
    #1;
    chk("stall_release_rdy", req0_rdy, 1);
    tick();
    req0_vld = 1'b0;
    chk("stall_second_req", mem_req, mk_req(10'h034, 8'd5));
    tick();
    chk("stall_drained", mem_req_vld, 0);
    send_resp(10'h033);
    send_resp(10'h034);
    chk("stall_busy_idle", busy, 0);

    // Credit limit
    req0_vld = 1'b1; req0 = mk_req(10'h011, 8'd6);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("credit_fill_rdy", req0_rdy, 1);
      tick();
    end
    req1_vld = 1'b1; req1 = mk_req(10'h022, 8'd7);
    #1;
    chk("credit_full_req0_rdy", req0_rdy, 0);
    chk("credit_full_req1_rdy", req1_rdy, 1);
    tick();
    req1_vld = 1'b0;
    mem_resp_vld = 1'b1; mem_resp = mk_resp(10'h000);
    #1;
    chk("credit_resp_cycle_rdy", req0_rdy, 0);
    tick();
    mem_resp_vld = 1'b0;
    #1;
    chk("credit_freed_rdy", req0_rdy, 1);
    mem_resp_vld = 1'b1; mem_resp = mk_resp(10'h000);
    tick();
    mem_resp_vld = 1'b0;
    #1;
    chk("credit_simul_rdy", req0_rdy, 1);
    tick();
    chk("credit_refull_rdy", req0_rdy, 0);
    req0_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_resp(10'h000);
    end
    send_resp(10'h200);
    chk("credit_busy_idle", busy, 0);
    chk("credit_err", err, 0);

    // Reset mid-transfer, then an orphan response
    mem_req_rdy = 1'b0;
    req0_vld = 1'b1; req0 = mk_req(10'h044, 8'd8);
    tick();
    req0_vld = 1'b0;
    chk("midrst_held", mem_req_vld, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_vld", mem_req_vld, 0);
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_busy", busy, 0);
    mem_resp_vld = 1'b1; mem_resp = mk_resp(10'h200);
    #1;
    chk("orphan_resp1_vld", resp1_vld, 1);
    chk("orphan_resp0_vld", resp0_vld, 0);
    tick();
    mem_resp_vld = 1'b0;
    chk("orphan_err", err, 1);
    chk("orphan_busy", busy, 0);
    tick();
    tick();
    chk("orphan_err_sticky", err, 1);
    mem_req_rdy = 1'b1;
    req1_vld = 1'b1; req1 = mk_req(10'h055, 8'd9);
    #1;
    chk("orphan_req1_rdy", req1_rdy, 1);
    tick();
    req1_vld = 1'b0;
    chk("orphan_mem_req", mem_req, mk_req(10'h255, 8'd9));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
